// File: rtl/game_pkg.sv
// Shared types and defaults for the game datapath slice.
package game_pkg;

    typedef enum logic [1:0] {
        LOBBY = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam int unsigned ADDR_NONE   = 0;
    localparam int unsigned DEF_ADDR_W  = 3;
    localparam int unsigned DEF_SCORE_W = 11;
    localparam int unsigned TIME_W      = 7;

endpackage

// File: rtl/game_datapath_n_if.sv
// Sensor/screen inputs and scoring/audio outputs of the game datapath.
interface game_datapath_n_if
    import game_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned SCORE_W = DEF_SCORE_W
) ();

    logic                start_game;
    logic [ADDR_W-1:0]   sensor_addr;
    logic [ADDR_W-1:0]   target_addr;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  misses;
    logic [TIME_W-1:0]   time_left;
    logic                hit_pulse;
    logic                miss_pulse;
    logic                play_sound;
    logic                lobby_sound;
    logic                game_over;
    logic [1:0]          state;

    modport slave (
        input  start_game, sensor_addr, target_addr,
        output score, misses, time_left, hit_pulse, miss_pulse,
               play_sound, lobby_sound, game_over, state
    );

    modport master (
        output start_game, sensor_addr, target_addr,
        input  score, misses, time_left, hit_pulse, miss_pulse,
               play_sound, lobby_sound, game_over, state
    );

endinterface

// File: rtl/game_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ enabled cycles; clear restarts the count.
module game_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;

    assign tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/game_datapath_n.sv
// Strike detection, scoring, countdown and sound requests for the multi-box game.
// Optional MISS_PENALTY_EN: each miss also takes one point off the score (floor 0).
module game_datapath_n
    import game_pkg::*;
#(
    parameter int unsigned NUM_BOXES    = 6,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned SCORE_W      = DEF_SCORE_W,
    parameter int unsigned GAME_SECONDS = 60,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned SOUND_CYCLES = 5_000_000
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    game_datapath_n_if.slave  bus
);

    localparam logic [ADDR_W-1:0] NONE     = ADDR_W'(ADDR_NONE);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_BOXES);
    localparam logic [TIME_W-1:0] T_INIT   = TIME_W'(GAME_SECONDS);

    state_t cur_state, nxt_state;

    logic [SYNC_STAGES-1:0][ADDR_W-1:0] sync_q;
    logic [ADDR_W-1:0]  prev_q, synced, tgt_prev_q;
    logic [SCORE_W-1:0] score_q, misses_q;
    logic [TIME_W-1:0]  time_q;
    logic hit_q, miss_q, play_q, lock_q, start_prev_q;
    logic tick_sec, tick_snd;
    logic strike, tgt_valid, on_target, final_tick, active, locked;
    logic hit_ev, miss_ev, launch, start_rise;

    assign synced     = sync_q[SYNC_STAGES-1];
    assign strike     = (synced != NONE) && (synced != prev_q) && (synced <= MAX_ADDR);
    assign tgt_valid  = (bus.target_addr != NONE) && (bus.target_addr <= MAX_ADDR);
    assign on_target  = tgt_valid && (synced == bus.target_addr);
    // The final tick wins over any strike resolving on the same edge.
    assign final_tick = (cur_state == PLAY) && tick_sec && (time_q == TIME_W'(1));
    assign active     = (cur_state == PLAY) && !final_tick;
    assign locked     = lock_q && (bus.target_addr == tgt_prev_q);
    assign hit_ev     = active && strike && on_target && !locked;
    assign miss_ev    = active && strike && !on_target;
    assign launch     = (cur_state == LOBBY) && bus.start_game;
    assign start_rise = bus.start_game && !start_prev_q;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sensor_addr};
            prev_q <= synced;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) cur_state <= LOBBY;
        else         cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state       = cur_state;
        bus.lobby_sound = 1'b0;
        bus.game_over   = 1'b0;
        case (cur_state)
            LOBBY: begin
                bus.lobby_sound = 1'b1;
                if (bus.start_game) nxt_state = PLAY;
            end
            PLAY: begin
                if (final_tick) nxt_state = OVER;
            end
            OVER: begin
                bus.game_over = 1'b1;
                if (start_rise) nxt_state = LOBBY;
            end
            default: nxt_state = LOBBY;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            score_q      <= '0;
            misses_q     <= '0;
            time_q       <= T_INIT;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            play_q       <= 1'b0;
            lock_q       <= 1'b0;
            tgt_prev_q   <= '0;
            start_prev_q <= 1'b0;
        end else begin
            hit_q        <= hit_ev;
            miss_q       <= miss_ev;
            tgt_prev_q   <= bus.target_addr;
            start_prev_q <= bus.start_game;

            if (launch) begin
                score_q  <= '0;
                misses_q <= '0;
                time_q   <= T_INIT;
                lock_q   <= 1'b0;
            end else if (cur_state == PLAY) begin
                if (tick_sec) time_q <= time_q - 1'b1;
                if (hit_ev) begin
                    if (score_q != '1) score_q <= score_q + 1'b1;
                    lock_q <= 1'b1;
                end else if (bus.target_addr != tgt_prev_q) begin
                    lock_q <= 1'b0;
                end
                if (miss_ev) begin
                    if (misses_q != '1) misses_q <= misses_q + 1'b1;
`ifdef MISS_PENALTY_EN
                    if (score_q != '0) score_q <= score_q - 1'b1;
`endif
                end
            end

            if (nxt_state != PLAY) play_q <= 1'b0;
            else if (hit_ev)       play_q <= 1'b1;
            else if (tick_snd)     play_q <= 1'b0;
        end
    end

    game_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .clear  (cur_state != PLAY),
        .enable (cur_state == PLAY),
        .tick   (tick_sec)
    );

    game_tick_gen #(.CLK_HZ(SOUND_CYCLES)) u_snd_tick (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .clear  (hit_ev || !play_q),
        .enable (play_q),
        .tick   (tick_snd)
    );

    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.time_left  = time_q;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.play_sound = play_q;
    assign bus.state      = cur_state;

endmodule
